// File: rtl/byte_frame_bridge.sv
// Byte-serial pad bridge: packs RX bytes into operand frames for a wide core
// and streams core results back out MSB-first with a byte strobe.
module byte_frame_bridge #(
  parameter int IN_WORDS  = 4,
  parameter int OUT_WORDS = 1,
  parameter int WORD_W    = 32,
  parameter int SKIP_DUP  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_byte,
  input  logic                          in_stb,
  input  logic                          in_sof,
  output logic [IN_WORDS*WORD_W-1:0]    frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  input  logic [OUT_WORDS*WORD_W-1:0]   res_data,
  input  logic                          res_valid,
  output logic                          res_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_stb,
  output logic                          res_tgl,
  output logic                          overrun
);

  localparam int IW  = IN_WORDS * WORD_W;
  localparam int OW  = OUT_WORDS * WORD_W;
  localparam int IB  = IW / 8;
  localparam int OB  = OW / 8;
  localparam int RCW = $clog2(IB + 1);
  localparam int TCW = $clog2(OB + 1);
  localparam logic [RCW-1:0] RX_LAST = RCW'(IB - 1);
  localparam logic [TCW-1:0] TX_LAST = TCW'(OB - 1);

  typedef enum logic { RX_FILL, RX_HOLD } rx_st_e;
  typedef enum logic { TX_IDLE, TX_SEND } tx_st_e;

  rx_st_e          rx_st_q, rx_st_d;
  logic [RCW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]   frame_q, frame_d;
  logic            ovr_q, ovr_d;

  tx_st_e          tx_st_q, tx_st_d;
  logic [TCW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [OW-1:0]   sh_q, sh_d;
  logic [OW-1:0]   last_q, last_d;
  logic            tgl_q, tgl_d;

  logic            take;
  logic            first;
  logic [RCW-1:0]  cnt_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q  <= RX_FILL;
      rx_cnt_q <= '0;
      frame_q  <= '0;
      ovr_q    <= 1'b0;
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      sh_q     <= '0;
      last_q   <= '0;
      tgl_q    <= 1'b0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      frame_q  <= frame_d;
      ovr_q    <= ovr_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      sh_q     <= sh_d;
      last_q   <= last_d;
      tgl_q    <= tgl_d;
    end
  end

  // A byte arriving with the HOLD handshake starts the next frame.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    frame_d  = frame_q;
    ovr_d    = 1'b0;
    take     = 1'b0;
    first    = 1'b0;
    cnt_cur  = rx_cnt_q;
    unique case (rx_st_q)
      RX_FILL: begin
        if (in_stb) begin
          take  = 1'b1;
          first = in_sof;
        end
      end
      RX_HOLD: begin
        if (frame_ready) begin
          rx_st_d  = RX_FILL;
          rx_cnt_d = '0;
          if (in_stb) begin
            take  = 1'b1;
            first = 1'b1;
          end
        end else if (in_stb) begin
          ovr_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      frame_d = (frame_q << 8) | IW'(in_byte);
      cnt_cur = first ? '0 : rx_cnt_q;
      if (cnt_cur == RX_LAST) begin
        rx_st_d  = RX_HOLD;
        rx_cnt_d = '0;
      end else begin
        rx_st_d  = RX_FILL;
        rx_cnt_d = cnt_cur + RCW'(1);
      end
    end
  end

  // Suppressed duplicates leave the shift register alone so out_byte holds.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    sh_d     = sh_q;
    last_d   = last_q;
    tgl_d    = tgl_q;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (res_valid &&
            !((SKIP_DUP != 0) && (res_data == last_q))) begin
          sh_d     = res_data;
          last_d   = res_data;
          tgl_d    = ~tgl_q;
          tx_st_d  = TX_SEND;
          tx_cnt_d = '0;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == TX_LAST) begin
          tx_st_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + TCW'(1);
          sh_d     = sh_q << 8;
        end
      end
      default: ;
    endcase
  end

  assign frame_data  = frame_q;
  assign frame_valid = (rx_st_q == RX_HOLD);
  assign overrun     = ovr_q;
  assign res_ready   = (tx_st_q == TX_IDLE);
  assign out_stb     = (tx_st_q == TX_SEND);
  assign out_byte    = sh_q[OW-1 -: 8];
  assign res_tgl     = tgl_q;

endmodule
